// File: rtl/oled_rx_pkg.sv
// ---------------------------------------------------------------------------
// oled_rx_pkg
// Shared types and constants for the OLED SPI receive slice.
//   BYTE_W             : width of one serial byte
//   DEFAULT_FIFO_DEPTH : default number of buffered received bytes
//   rx_state_e         : receive FSM states (IDLE, SHIFT)
//   rx_entry_t         : one FIFO entry, D/C flag packed above the data byte
// ---------------------------------------------------------------------------
package oled_rx_pkg;

   localparam int BYTE_W             = 8;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

   typedef struct packed {
      logic              is_data;
      logic [BYTE_W-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/oled_spi_rx_if.sv
// ---------------------------------------------------------------------------
// oled_spi_rx_if
// Received-byte handshake between the SPI receiver and its consumer.
//   RxData   : head-of-FIFO byte
//   RxIsData : D/C flag captured with RxData (1 = data, 0 = command)
//   RxValid  : FIFO non-empty
//   RxReady  : consumer accepts the head byte when RxValid & RxReady
// master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface oled_spi_rx_if;
   import oled_rx_pkg::*;

   logic [BYTE_W-1:0] RxData;
   logic              RxIsData;
   logic              RxValid;
   logic              RxReady;

   modport master (output RxData, RxIsData, RxValid, input  RxReady);
   modport slave  (input  RxData, RxIsData, RxValid, output RxReady);

endinterface

// File: rtl/oled_rx_fifo.sv
// ---------------------------------------------------------------------------
// oled_rx_fifo
// Synchronous FIFO for received bytes with a defined head value when empty.
//   Clock, nReset : system clock, asynchronous active-low reset
//   push_i        : write push_data_i (accepted when not full, or when full
//                   and a pop happens in the same cycle)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : head entry; while empty it holds the last head shown
//   full_o/empty_o: occupancy flags
// ---------------------------------------------------------------------------
module oled_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] hold_q;
   logic             empty, full;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      do_pop   = pop_i & ~empty;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push  = push_i & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // NOTE: storage has no reset; an entry is only ever read after it has been
   // written, and leaving it unreset keeps it mappable to plain RAM/flops.
   always_ff @(posedge Clock) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (!empty) hold_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   // Empty selects the held copy so the head never exposes unwritten storage.
   assign head_o  = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
   assign full_o  = full;
   assign empty_o = empty;

endmodule

// File: rtl/oled_spi_rx.sv
// ---------------------------------------------------------------------------
// oled_spi_rx
// SPI-style receiver snooping the serial link to an OLED display driver.
// Bytes are shifted in MSB first on SCLK rises while nCS is low, tagged with
// DnC sampled on the last bit, and buffered in a small FIFO.
//   Clock, nReset : system clock, asynchronous active-low reset
//   SCLK, SDIN    : serial clock / data (asynchronous to Clock)
//   DnC           : 1 = data byte, 0 = command byte
//   nCS           : active-low byte framing
//   rx            : received-byte handshake (oled_spi_rx_if.master)
//   Overflow      : sticky, completed byte dropped because FIFO full
//   FrameErr      : sticky, nCS released with a partial byte
//   ClearErr      : synchronous clear of both sticky flags (a new error wins)
// ---------------------------------------------------------------------------
module oled_spi_rx
   import oled_rx_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic Clock,
   input  logic nReset,
   input  logic SCLK,
   input  logic SDIN,
   input  logic DnC,
   input  logic nCS,
   input  logic ClearErr,
   oled_spi_rx_if.master rx,
   output logic Overflow,
   output logic FrameErr
);

   localparam int CNT_W = $clog2(BYTE_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sdin_sync_q, dnc_sync_q, ncs_sync_q;
   logic                   sclk_s, sdin_s, dnc_s, ncs_s;
   logic                   sclk_prev_q, sclk_rise;

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic              overflow_q, overflow_d;
   logic              frame_err_q, frame_err_d;

   logic              push, pop, frame_set, overflow_set;
   rx_entry_t         push_entry, head;
   logic              fifo_full, fifo_empty;

   // Synchronisers; nCS resets to its inactive level so no frame is implied.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sclk_sync_q <= '0;
         sdin_sync_q <= '0;
         dnc_sync_q  <= '0;
         ncs_sync_q  <= '1;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], SDIN};
         dnc_sync_q  <= {dnc_sync_q[SYNC_STAGES-2:0], DnC};
         ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
         sclk_prev_q <= sclk_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
   assign dnc_s     = dnc_sync_q[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;

   // Receive FSM, bit counter and shift register.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      push       = 1'b0;
      push_entry = '0;
      frame_set  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!ncs_s) state_d = SHIFT;
         end
         SHIFT: begin
            if (ncs_s) begin
               // Frame closed: any partial byte is discarded and flagged.
               state_d   = IDLE;
               cnt_d     = '0;
               shift_d   = '0;
               frame_set = (cnt_q != '0);
            end else if (sclk_rise) begin
               shift_d = {shift_q[BYTE_W-2:0], sdin_s};
               cnt_d   = cnt_q + CNT_W'(1);   // wraps to 0 after the last bit
               if (cnt_q == LAST_BIT) begin
                  push               = 1'b1;
                  push_entry.data    = shift_d;
                  push_entry.is_data = dnc_s;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop          = rx.RxReady & ~fifo_empty;
   assign overflow_set = push & fifo_full & ~pop;

   // Sticky flags: a new event in the clearing cycle keeps the flag set.
   always_comb begin
      overflow_d  = (overflow_q  & ~ClearErr) | overflow_set;
      frame_err_d = (frame_err_q & ~ClearErr) | frame_set;
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   oled_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(rx_entry_t))
   ) u_fifo (
      .Clock       (Clock),
      .nReset      (nReset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign rx.RxData   = head.data;
   assign rx.RxIsData = head.is_data;
   assign rx.RxValid  = ~fifo_empty;
   assign Overflow    = overflow_q;
   assign FrameErr    = frame_err_q;

endmodule
